// File: rtl/uart_boot_loader.sv
// UART boot loader: receives 8N1 bytes, takes a word-count header followed by
// lo/hi byte pairs, and writes 9-bit words into a 128-word program SRAM.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no session; received bytes are dropped
// HDR   | waiting for the word-count byte
// LO    | waiting for the low byte of the next word
// HI    | waiting for the high byte (only bit 0 may be set)
// WR    | one-cycle SRAM write of mem_addr / mem_data
// DONE  | all words written, load_done high until load_en falls
// ERR   | framing or high-byte error, waits for load_en to fall
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       SYS_CLK,
  input  logic       reset_n,
  input  logic       uart_rx,
  input  logic       load_en,
  output logic [6:0] mem_addr,
  output logic [8:0] mem_data,
  output logic       mem_wren,
  output logic       load_busy,
  output logic       load_done,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LO, S_HI, S_WR, S_DONE, S_ERR} state_t;

  logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_valid, byte_err;

  state_t          state_q, state_d;
  logic [7:0]      word_cnt_q, word_cnt_d;
  logic [6:0]      mem_addr_q, mem_addr_d;
  logic [8:0]      mem_data_q, mem_data_d;
  logic            frame_err_q, frame_err_d;

  // All state registers; synchronizer flops reset to the idle-high line level.
  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Receiver next state: edge detect, half-bit start check, centre sampling.
  always_comb begin
    rx_meta_d  = uart_rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_RELOAD;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_RELOAD;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) rx_state_d = RX_IDLE;
        else                rx_cnt_d   = rx_cnt_q - CW'(1);
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver outputs: one-cycle strobes at the stop-bit sample.
  always_comb begin
    byte_valid = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_sync_q;
    byte_err   = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && !rx_sync_q;
  end

  // Loader next state and datapath; load_en low aborts any active session.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    frame_err_d = frame_err_q;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d     = S_HDR;
          frame_err_d = 1'b0;
          mem_addr_d  = '0;
        end
      end
      S_HDR, S_LO, S_HI: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (byte_err) begin
          state_d     = S_ERR;
          frame_err_d = 1'b1;
        end else if (byte_valid) begin
          if (state_q == S_HDR) begin
            // zero and anything beyond the memory size both mean a full load
            word_cnt_d = (rx_shift_q == 8'd0 || rx_shift_q > 8'd128) ? 8'd128 : rx_shift_q;
            mem_addr_d = '0;
            state_d    = S_LO;
          end else if (state_q == S_LO) begin
            mem_data_d[7:0] = rx_shift_q;
            state_d         = S_HI;
          end else if (rx_shift_q[7:1] != 7'd0) begin
            state_d     = S_ERR;
            frame_err_d = 1'b1;
          end else begin
            mem_data_d[8] = rx_shift_q[0];
            state_d       = S_WR;
          end
        end
      end
      S_WR: begin
        // the write strobe in this cycle completes even on abort
        if (!load_en) begin
          state_d = S_IDLE;
        end else begin
          word_cnt_d = word_cnt_q - 8'd1;
          if (word_cnt_q == 8'd1) begin
            state_d = S_DONE;
          end else begin
            mem_addr_d = mem_addr_q + 7'd1;
            state_d    = S_LO;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!load_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Loader outputs decoded from the current state.
  always_comb begin
    mem_wren  = (state_q == S_WR);
    load_busy = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    load_done = (state_q == S_DONE);
    mem_addr  = mem_addr_q;
    mem_data  = mem_data_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: serial byte stimulus, a session
// reference model over the byte stream, and a write monitor.
module tb_uart_boot_loader;

  localparam int CPB = 8;

  logic       SYS_CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       load_en = 1'b0;
  logic [6:0] mem_addr;
  logic [8:0] mem_data;
  logic       mem_wren;
  logic       load_busy;
  logic       load_done;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  stim_q[$];
  bit          exp_err;
  bit          exp_done;

  uart_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
    .SYS_CLK   (SYS_CLK),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .load_en   (load_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wren  (mem_wren),
    .load_busy (load_busy),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // record every write as {addr, data}
  always @(negedge SYS_CLK) if (mem_wren === 1'b1) wr_q.push_back({mem_addr, mem_data});

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge SYS_CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge SYS_CLK);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge SYS_CLK);
    uart_rx = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge SYS_CLK);
  endtask

  task automatic send_stim;
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b1);
    repeat (4) @(negedge SYS_CLK);
  endtask

  // Session model: header gives word count (0 or >128 => 128), then lo/hi
  // pairs; a high byte above 1 stops the session with an error.
  task automatic run_model;
    int n;
    logic [7:0] lo, hi;
    exp_q.delete();
    exp_err  = 0;
    exp_done = 0;
    if (stim_q.size() == 0) return;
    n = (stim_q[0] == 8'd0 || stim_q[0] > 8'd128) ? 128 : int'(stim_q[0]);
    for (int w = 0; w < n; w++) begin
      if (2 * w + 2 >= stim_q.size()) return;
      lo = stim_q[2 * w + 1];
      hi = stim_q[2 * w + 2];
      if (hi > 8'd1) begin
        exp_err = 1;
        return;
      end
      exp_q.push_back({7'(w), hi[0], lo});
    end
    exp_done = 1;
  endtask

  task automatic random_words(input int hdr, input int n);
    stim_q.delete();
    stim_q.push_back(8'(hdr));
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(8'($urandom));
      stim_q.push_back(8'($urandom_range(0, 1)));
    end
  endtask

  task automatic end_session;
    load_en = 1'b0;
    repeat (3) @(negedge SYS_CLK);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    checks++;
    if ({mem_addr, mem_data, mem_wren, load_busy, load_done, frame_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {mem_addr, mem_data, mem_wren, load_busy, load_done, frame_err});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    checks++;
    if (load_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b exp 0", load_busy);
    end
  endtask

  task automatic test_basic;
    wr_q.delete();
    stim_q = '{8'h02, 8'h34, 8'h01, 8'hFF, 8'h00};
    run_model();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    checks++;
    if (load_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b exp 1", load_busy);
    end
    send_stim();
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count got %0d exp 2", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 16'h0134 || wr_q[1] !== 16'h02FF) begin
        errors++;
        $display("FAIL basic_words got %h %h exp 0134 02ff", wr_q[0], wr_q[1]);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_model[%0d] got %h exp %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({load_done, load_busy, frame_err} !== 3'b100) begin
      errors++;
      $display("FAIL basic_done done/busy/err got %b exp 100", {load_done, load_busy, frame_err});
    end
    end_session();
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_clear got %b exp 0", load_done);
    end
  endtask

  task automatic test_random_sessions;
    for (int s = 0; s < 4; s++) begin
      wr_q.delete();
      random_words($urandom_range(1, 5), 0);
      for (int i = 0; i < int'(stim_q[0]); i++) begin
        stim_q.push_back(8'($urandom));
        stim_q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
      end
      run_model();
      load_en = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      send_stim();
      checks++;
      if (wr_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d exp %0d", s, wr_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (wr_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_word[%0d] got %h exp %h", s, i, wr_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if ({load_done, frame_err} !== {exp_done, exp_err}) begin
        errors++;
        $display("FAIL rand%0d_status done/err got %b%b exp %b%b", s, load_done, frame_err, exp_done, exp_err);
      end
      end_session();
    end
  endtask

  task automatic test_full;
    for (int k = 0; k < 2; k++) begin
      wr_q.delete();
      random_words((k == 0) ? 0 : $urandom_range(129, 255), 128);
      run_model();
      load_en = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      send_stim();
      repeat (5 * CPB) @(negedge SYS_CLK);
      checks++;
      if (wr_q.size() != 128 || exp_q.size() != 128) begin
        errors++;
        $display("FAIL full%0d_count got %0d exp 128", k, wr_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (wr_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL full%0d_word[%0d] got %h exp %h", k, i, wr_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if ({load_done, load_busy} !== 2'b10) begin
        errors++;
        $display("FAIL full%0d_done done/busy got %b%b exp 10", k, load_done, load_busy);
      end
      end_session();
    end
  endtask

  task automatic test_stop_err;
    wr_q.delete();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    send_byte(8'h03, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge SYS_CLK);
    checks++;
    if ({frame_err, load_busy, load_done} !== 3'b100 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL stop_err err/busy/done got %b%b%b writes %0d exp 100 writes 0",
               frame_err, load_busy, load_done, wr_q.size());
    end
    end_session();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL stop_err_sticky got %b exp 1", frame_err);
    end
    stim_q = '{8'h01, 8'hA5, 8'h01};
    run_model();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    send_stim();
    checks++;
    if (frame_err !== 1'b0 || wr_q.size() != 1) begin
      errors++;
      $display("FAIL stop_err_recover err %b writes %0d exp 0 writes 1", frame_err, wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL stop_err_word got %h exp %h", wr_q[0], exp_q[0]);
      end
    end
    end_session();
  endtask

  task automatic test_bad_high;
    wr_q.delete();
    stim_q = '{8'h01, 8'h12, 8'h02};
    run_model();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    send_stim();
    checks++;
    if (frame_err !== exp_err || wr_q.size() != exp_q.size() || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_high err %b writes %0d busy %b exp err %b writes %0d busy 0",
               frame_err, wr_q.size(), load_busy, exp_err, exp_q.size());
    end
    end_session();
  endtask

  task automatic test_glitch;
    wr_q.delete();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    uart_rx = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge SYS_CLK);
    stim_q = '{8'h01, 8'h3C, 8'h00};
    run_model();
    send_stim();
    checks++;
    if (wr_q.size() != 1 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL glitch writes %0d done %b exp writes 1 done 1", wr_q.size(), load_done);
    end else begin
      checks++;
      if (wr_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL glitch_word got %h exp %h", wr_q[0], exp_q[0]);
      end
    end
    end_session();
  endtask

  task automatic test_abort;
    wr_q.delete();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    send_byte(8'h03, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h01, 1'b1);
    load_en = 1'b0;
    @(negedge SYS_CLK);
    checks++;
    if (load_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b exp 0", load_busy);
    end
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h01, 1'b1);
    checks++;
    if (wr_q.size() != 1) begin
      errors++;
      $display("FAIL abort_count got %0d exp 1", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== {7'd0, 9'h177}) begin
        errors++;
        $display("FAIL abort_word got %h exp %h", wr_q[0], {7'd0, 9'h177});
      end
    end
  endtask

  task automatic test_idle_drop;
    wr_q.delete();
    load_en = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++;
    if (wr_q.size() != 0 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop writes %0d busy %b exp 0 0", wr_q.size(), load_busy);
    end
    random_words(2, 2);
    run_model();
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    send_stim();
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL idle_after_count got %0d exp 2", wr_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL idle_after_word[%0d] got %h exp %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    end_session();
  endtask

  task automatic test_reset_mid;
    load_en = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    send_byte(8'h02, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge SYS_CLK);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_addr, mem_data, mem_wren, load_busy, load_done, frame_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %h exp 0", {mem_addr, mem_data, mem_wren, load_busy, load_done, frame_err});
    end
    uart_rx = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    reset_n = 1'b1;
    wr_q.delete();
    repeat (2) @(negedge SYS_CLK);
    random_words(2, 2);
    run_model();
    send_stim();
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL reset_mid_count got %0d exp 2", wr_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL reset_mid_word[%0d] got %h exp %h", i, wr_q[i], exp_q[i]);
        end
      end
    end
    end_session();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_sessions();
    test_stop_err();
    test_bad_high();
    test_glitch();
    test_abort();
    test_idle_drop();
    test_reset_mid();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
